// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory responder.
//   - request size encodings (SZ_BYTE / SZ_HALF / SZ_WORD; 2'b11 behaves as word)
//   - FSM state type dmem_state_t {IDLE, BUSY, RESP}
//   - default wait-state count
//   - is_misaligned(): alignment check used when DMEM_MISALIGN_ERR_EN is defined
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int DMEM_WAIT_DEFAULT = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  // Halves must sit on even addresses; words (and the 2'b11 size) on multiples of 4.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    if (size == SZ_HALF) mis = addr_lo[0];
    else if (size[1])    mis = (addr_lo != 2'b00);
    return mis;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: load/store request and response bundle between the core
// (master) and the data-memory responder (slave).
//   req_valid/req_ready : request handshake
//   req_we              : 1 = store, 0 = load
//   req_size            : 00 byte, 01 half, 10/11 word
//   req_addr            : byte address
//   req_wdata           : right-aligned store data
//   rsp_valid           : one-cycle response strobe
//   rsp_rdata           : right-aligned, zero-extended load data (0 for stores)
//   rsp_err             : misaligned-access flag, qualified by rsp_valid
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_lane.sv
// dmem_lane: combinational byte-lane steering for the data memory.
//   size, addr_lo : access size and low two address bits
//   wdata         : right-aligned store data
//   rword         : full memory word at the addressed index
//   be            : byte enables for the store
//   wword         : store data replicated into every candidate lane
//   rdata         : selected byte/half shifted to bit 0, zero-extended
// Sub-word offsets are always aligned to the access size here (addr[0] dropped
// for halves, addr[1:0] dropped for words); rejecting misaligned requests is
// the parent's decision.
module dmem_lane
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wword,
  output logic [31:0] rdata
);

  always_comb begin
    be    = 4'b1111;
    wword = wdata;
    rdata = rword;
    case (size)
      SZ_BYTE: begin
        be    = 4'b0001 << addr_lo;
        wword = {4{wdata[7:0]}};
        case (addr_lo)
          2'd0:    rdata = {24'h0, rword[7:0]};
          2'd1:    rdata = {24'h0, rword[15:8]};
          2'd2:    rdata = {24'h0, rword[23:16]};
          default: rdata = {24'h0, rword[31:24]};
        endcase
      end
      SZ_HALF: begin
        be    = addr_lo[1] ? 4'b1100 : 4'b0011;
        wword = {2{wdata[15:0]}};
        rdata = addr_lo[1] ? {16'h0, rword[31:16]} : {16'h0, rword[15:0]};
      end
      default: begin
        be    = 4'b1111;
        wword = wdata;
        rdata = rword;
      end
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: memory end of the core's load/store port. Accepts one
// request at a time, waits WAIT_CYCLES cycles, then returns a one-cycle
// response. Stores commit and loads read on the edge that enters RESP.
//   clk   : rising-edge clock
//   reset : synchronous, active-low
//   bus   : dmem_responder_if.slave (request handshake + response)
// Parameters:
//   DEPTH_WORDS : 32-bit words in the array (power of two, >= 4)
//   WAIT_CYCLES : wait states between accept and response (0 allowed)
// Build option:
//   DMEM_MISALIGN_ERR_EN : when defined, misaligned halves/words do not write,
//   return 0 and raise rsp_err; otherwise they are silently aligned and
//   rsp_err is tied low.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = DMEM_WAIT_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  dmem_responder_if.slave bus
);

  localparam int AW    = $clog2(DEPTH_WORDS);
  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [31:0] mem [DEPTH_WORDS];

  dmem_state_t      state;
  logic [CNT_W-1:0] cnt;
  logic             ready_r;
  logic             valid_r;
  logic [31:0]      rdata_r;

  logic             we_p1;
  logic [1:0]       size_p1;
  logic [AW+1:0]    addr_p1;
  logic [31:0]      wdata_p1;

  logic             c_we;
  logic [1:0]       c_size;
  logic [AW+1:0]    c_addr;
  logic [31:0]      c_wdata;
  logic [AW-1:0]    c_idx;
  logic             c_mis;

  logic             accept;
  logic             enter_resp;
  logic             wr_en;
  logic [3:0]       lane_be;
  logic [31:0]      lane_wword;
  logic [31:0]      lane_rdata;

  // Address bits above the array size only alias; they are intentionally dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.req_addr[31:AW+2];

  assign accept = bus.req_valid && ready_r;

  // ---- request capture (accept edge) ----
  always_ff @(posedge clk) begin
    if (accept) begin
      we_p1    <= bus.req_we;
      size_p1  <= bus.req_size;
      addr_p1  <= bus.req_addr[AW+1:0];
      wdata_p1 <= bus.req_wdata;
    end
  end

  // With no wait states RESP is entered on the accept edge itself, so the
  // commit must use the live request rather than the captured copy.
  always_comb begin
    if (WAIT_CYCLES == 0) begin
      c_we    = bus.req_we;
      c_size  = bus.req_size;
      c_addr  = bus.req_addr[AW+1:0];
      c_wdata = bus.req_wdata;
    end else begin
      c_we    = we_p1;
      c_size  = size_p1;
      c_addr  = addr_p1;
      c_wdata = wdata_p1;
    end
  end

  assign c_idx = c_addr[AW+1:2];

`ifdef DMEM_MISALIGN_ERR_EN
  assign c_mis = is_misaligned(c_size, c_addr[1:0]);
`else
  assign c_mis = 1'b0;
`endif

  assign enter_resp = ((state == IDLE) && accept && (WAIT_CYCLES == 0)) ||
                      ((state == BUSY) && (cnt == CNT_ONE));

  // Reset wins over a pending commit, so a store aborted by reset never lands.
  assign wr_en = reset && enter_resp && c_we && !c_mis;

  dmem_lane u_lane (
    .size    (c_size),
    .addr_lo (c_addr[1:0]),
    .wdata   (c_wdata),
    .rword   (mem[c_idx]),
    .be      (lane_be),
    .wword   (lane_wword),
    .rdata   (lane_rdata)
  );

  // ---- commit / read (edge entering RESP) ----
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (lane_be[b]) mem[c_idx][8*b +: 8] <= lane_wword[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      ready_r <= 1'b1;
      valid_r <= 1'b0;
      rdata_r <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            ready_r <= 1'b0;
            if (WAIT_CYCLES == 0) begin
              state   <= RESP;
              valid_r <= 1'b1;
            end else begin
              state <= BUSY;
              cnt   <= CNT_INIT;
            end
          end
        end
        BUSY: begin
          cnt <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            state   <= RESP;
            valid_r <= 1'b1;
          end
        end
        RESP: begin
          state   <= IDLE;
          valid_r <= 1'b0;
          ready_r <= 1'b1;
        end
        default: begin
          state   <= IDLE;
          valid_r <= 1'b0;
          ready_r <= 1'b1;
        end
      endcase
      if (enter_resp) begin
        rdata_r <= (c_we || c_mis) ? 32'h0 : lane_rdata;
      end
    end
  end

`ifdef DMEM_MISALIGN_ERR_EN
  logic err_r;
  always_ff @(posedge clk) begin
    if (!reset)          err_r <= 1'b0;
    else if (enter_resp) err_r <= c_mis;
  end
  assign bus.rsp_err = err_r;
`else
  assign bus.rsp_err = 1'b0;
`endif

  assign bus.req_ready = ready_r;
  assign bus.rsp_valid = valid_r;
  assign bus.rsp_rdata = rdata_r;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder: the memory end of the core's load/store interface.
- Accepts one load or store request at a time over a valid/ready handshake.
- Inserts a configurable number of wait states, then returns a single-cycle response.
- Sits between the core's ALU-result/store-data outputs and its read-data input, replacing the zero-latency memory model so multi-cycle memory can be exercised.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words; power of two, minimum 4.
- WAIT_CYCLES, 2, wait states between accept and response; 0 is legal.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset).
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request this cycle.
- req_we  input  1  1 = store, 0 = load.
- req_size  input  2  00 = byte, 01 = half, 10 = word, 11 = treated as word.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-aligned: byte in [7:0], half in [15:0].
- rsp_valid  output  1  one-cycle response strobe.
- rsp_rdata  output  32  load data, right-aligned, zero-extended; 0 for stores.
- rsp_err  output  1  misaligned-access flag, qualified by rsp_valid.

Behaviour:
- Reset (reset = 0 at an edge):
  - State goes to IDLE; wait counter goes to 0.
  - Outputs: req_ready = 1 (IDLE), rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
  - Memory array contents are not cleared.
- FSM states: IDLE, BUSY, RESP.
  - IDLE: req_ready = 1. A request is accepted when req_valid and req_ready are both 1; we, size, addr and wdata are latched. Next state is BUSY with counter = WAIT_CYCLES, or RESP if WAIT_CYCLES = 0.
  - BUSY: req_ready = 0. Counter decrements each cycle; when it reaches 1, next state is RESP.
  - RESP: rsp_valid = 1 for exactly one cycle, req_ready = 0; next state is IDLE.
- Latency and throughput:
  - Accept in cycle T gives rsp_valid in cycle T+1+WAIT_CYCLES.
  - Maximum throughput is one request per WAIT_CYCLES+2 cycles.
  - req_valid during BUSY or RESP is ignored; the requester must hold it until accepted.
- Addressing:
  - Word index = addr[log2(DEPTH_WORDS)+1:2]; higher address bits are ignored, so addresses wrap modulo 4*DEPTH_WORDS.
- Store commit:
  - Byte lanes are written on the clock edge that enters RESP.
  - Byte: lane addr[1:0] gets wdata[7:0].
  - Half: lanes {addr[1],0} and {addr[1],1} get wdata[15:0].
  - Word: all four lanes get wdata.
- Load data:
  - The word is read on the edge entering RESP.
  - The selected byte or half is shifted down to bit 0 and zero-extended; rsp_rdata is registered and held until the next response.
  - Sign extension is the core's job.
- Reset during BUSY: the operation is aborted and any uncommitted store is discarded. Reset during RESP: rsp_valid drops next cycle; a committed store remains.
- Load-after-store to the same address returns the new data (the store committed before the load was accepted).

Optional Feature:
- Macro: DMEM_MISALIGN_ERR_EN.
- Defined:
  - A half with addr[0] = 1, or a word with addr[1:0] != 0, is misaligned.
  - A misaligned request performs no write, returns rsp_rdata = 0 and raises rsp_err = 1 together with rsp_valid.
  - Timing is unchanged.
- Undefined:
  - rsp_err is tied to 0.
  - Halves force addr[0] = 0 and words force addr[1:0] = 0, so accesses are silently aligned.

Decomposition:
- Package dmem_pkg holds:
  - size encoding constants: SZ_BYTE, SZ_HALF, SZ_WORD;
  - FSM state enum: dmem_state_t {IDLE, BUSY, RESP};
  - default WAIT_CYCLES constant.
- Sub-module dmem_lane (combinational) generates the 4-bit byte enable and aligned write word from size/addr/wdata, and does the read-side lane extraction.
- The FSM and array stay in dmem_responder.

Test Plan:
- Reset, WAIT_CYCLES=2: hold reset=0 for 2 cycles -> req_ready=1, rsp_valid=0, rsp_rdata=0. Then word store 0xDEADBEEF to 0x10 accepted at T -> rsp_valid high only at T+3, req_ready low T+1..T+3.
- Byte store 0xAA to 0x13, then word load 0x10 -> rsp_rdata=0xAADEBEEF? No: expect 0xAAADBEEF (lane 3 replaced). Then byte load 0x13 -> 0x000000AA; half load 0x12 -> 0x0000AAAD.
- WAIT_CYCLES=0: back-to-back requests with req_valid held -> accepts every 2nd cycle; each rsp_valid one cycle after accept.
- Wrap, DEPTH_WORDS=1024: store 0x12345678 to 0x1010, load 0x0010 -> 0x12345678.
- Reset asserted in the cycle after accepting a store of 0x55 to 0x20 (WAIT=2) -> no response; subsequent load 0x20 returns the prior value.
- With DMEM_MISALIGN_ERR_EN: word store 0xFFFFFFFF to 0x22 -> rsp_err=1, rsp_rdata=0, memory unchanged. Without the macro -> rsp_err=0 and the store lands at 0x20.
